// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared core parameters: fetch-control state encoding, redirect defaults and
// the RV32 major opcodes that produce redirects further down the pipe.
package pc_redirect_ctrl_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam int DEFAULT_FLUSH_DEPTH = 3;
  localparam int FLUSH_CNT_W         = 3;

  // Major opcodes whose execution can assert jb_enable or trap_req.
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_JB   = 2'd1,
    REDIR_TRAP = 2'd2
  } redirect_e;

  function automatic logic [31:0] pc_incr(input logic [31:0] cur);
    return cur + 32'd1;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: sequential fetch, jump/branch and trap redirects with a
// fixed-length pipeline flush, plus a debug halt state.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          FLUSH_DEPTH = DEFAULT_FLUSH_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        jb_enable,
  input  logic [31:0] jb_target_pc,
  input  logic        trap_req,
  input  logic [31:0] trap_vector,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush,
  output logic        trap_ack,
  output logic [31:0] epc,
  output logic        halted,
  output logic [31:0] redirect_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_DEPTH);

  logic [1:0]             state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  logic                   run;
  redirect_e              redir;

  assign run = (state == ST_RUN);

  // Trap outranks jb; both are only taken while running.
  always_comb begin
    redir = REDIR_NONE;
    if (run) begin
      if (trap_req)
        redir = REDIR_TRAP;
      else if (jb_enable)
        redir = REDIR_JB;
    end
  end

  assign fetch_valid = run && !stall;
  assign halted      = (state == ST_HALT);
  // Gated by reset_n so a held trap_req cannot be acknowledged during reset.
  assign trap_ack    = reset_n && (redir == REDIR_TRAP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_RUN;
      pc           <= RESET_PC;
      epc          <= 32'h0;
      flush        <= 1'b0;
      flush_cnt    <= '0;
      redirect_cnt <= 32'h0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redir != REDIR_NONE) begin
            state        <= ST_FLUSH;
            flush        <= 1'b1;
            flush_cnt    <= FLUSH_LOAD;
            redirect_cnt <= redirect_cnt + 32'd1;
            if (redir == REDIR_TRAP) begin
              pc  <= trap_vector;
              // A jb taken alongside the trap is where execution would have resumed.
              epc <= jb_enable ? jb_target_pc : pc;
            end else begin
              pc <= jb_target_pc;
            end
          end else if (halt_req) begin
            state <= ST_HALT;
          end else if (fetch_valid && imem_ready) begin
            pc <= pc_incr(pc);
          end
        end
        ST_FLUSH: begin
          // Counts unconditionally; stall only gates fetch, never the flush window.
          flush_cnt <= flush_cnt - 1'b1;
          if (flush_cnt == FLUSH_CNT_W'(1)) begin
            state <= ST_RUN;
            flush <= 1'b0;
          end
        end
        ST_HALT: begin
          if (!halt_req)
            state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model of the fetch/redirect rules.
module tb_pc_redirect_ctrl;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          DEPTH  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jb_enable = 1'b0;
  logic [31:0] jb_target_pc = 32'h0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vector = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b1;
  logic        halt_req = 1'b0;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush;
  logic        trap_ack;
  logic [31:0] epc;
  logic        halted;
  logic [31:0] redirect_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining flush cycles and a halt flag instead of an explicit state.
  logic [31:0] m_pc, m_epc, m_cnt;
  int          m_flush_left;
  logic        m_halt;

  pc_redirect_ctrl #(.RESET_PC(RST_PC), .FLUSH_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .jb_enable(jb_enable), .jb_target_pc(jb_target_pc),
    .trap_req(trap_req), .trap_vector(trap_vector), .stall(stall),
    .imem_ready(imem_ready), .halt_req(halt_req), .pc(pc), .fetch_valid(fetch_valid),
    .flush(flush), .trap_ack(trap_ack), .epc(epc), .halted(halted),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic m_running();
    return (m_flush_left == 0) && !m_halt;
  endfunction

  function automatic logic exp_fv();
    return m_running() && !stall;
  endfunction

  function automatic logic exp_ack();
    return m_running() && trap_req;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_epc = 32'h0; m_cnt = 32'h0; m_flush_left = 0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    if (m_running()) begin
      if (trap_req) begin
        m_epc = jb_enable ? jb_target_pc : m_pc;
        m_pc = trap_vector; m_cnt = m_cnt + 32'd1; m_flush_left = DEPTH;
      end else if (jb_enable) begin
        m_pc = jb_target_pc; m_cnt = m_cnt + 32'd1; m_flush_left = DEPTH;
      end else if (halt_req) begin
        m_halt = 1'b1;
      end else if (!stall && imem_ready) begin
        m_pc = m_pc + 32'd1;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
    end else if (!halt_req) begin
      m_halt = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    jb_enable = 1'b0; trap_req = 1'b0; stall = 1'b0; halt_req = 1'b0;
    imem_ready = 1'b1; jb_target_pc = 32'h0; trap_vector = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    trap_req = 1'b1;
    reset_n = 1'b0;
    #3;
    n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
    n_checks++; if (trap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_trap_ack got %b want 0", trap_ack); end
    n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want 0", epc); end
    n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", redirect_cnt); end
    @(negedge clk);
    trap_req = 1'b0;
    reset_n = 1'b1;
    model_reset();
    #1;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (pc !== 32'(i)) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, i); end
      n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL seq_fv[%0d] got %b want 1", i, fetch_valid); end
      n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL seq_flush[%0d] got %b want 0", i, flush); end
      tick();
    end
  endtask

  task automatic test_jb_redirect();
    do_reset();
    repeat (5) tick();
    n_checks++; if (pc !== 32'd5) begin n_fail++; $display("FAIL jb_start_pc got %h want 5", pc); end
    jb_enable = 1'b1; jb_target_pc = 32'h40;
    tick();
    jb_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL jb_pc[%0d] got %h want 40", i, pc); end
      n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jb_flush[%0d] got %b want 1", i, flush); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL jb_fv[%0d] got %b want 0", i, fetch_valid); end
      tick();
    end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jb_flush_end got %b want 0", flush); end
    n_checks++; if (fetch_valid !== 1'b1 || pc !== 32'h40) begin n_fail++; $display("FAIL jb_refetch got fv=%b pc=%h want fv=1 pc=40", fetch_valid, pc); end
    n_checks++; if (redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL jb_cnt got %0d want 1", redirect_cnt); end
  endtask

  task automatic test_trap_jb();
    do_reset();
    repeat (2) tick();
    trap_req = 1'b1; jb_enable = 1'b1; jb_target_pc = 32'h40; trap_vector = 32'h100;
    #1;
    n_checks++; if (trap_ack !== 1'b1) begin n_fail++; $display("FAIL trap_ack_pulse got %b want 1", trap_ack); end
    tick();
    trap_req = 1'b0; jb_enable = 1'b0;
    #1;
    n_checks++; if (trap_ack !== 1'b0) begin n_fail++; $display("FAIL trap_ack_drop got %b want 0", trap_ack); end
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL trap_pc got %h want 100", pc); end
    n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL trap_epc got %h want 40", epc); end
    n_checks++; if (redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL trap_cnt got %0d want 1", redirect_cnt); end
    repeat (3) tick();
  endtask

  task automatic test_jb_in_flush();
    do_reset();
    repeat (3) tick();
    jb_enable = 1'b1; jb_target_pc = 32'h20;
    tick();
    jb_enable = 1'b0;
    tick();
    jb_enable = 1'b1; jb_target_pc = 32'h99;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL jbf_flush2 got %b want 1", flush); end
    tick();
    jb_enable = 1'b0;
    n_checks++; if (pc !== 32'h20) begin n_fail++; $display("FAIL jbf_pc got %h want 20", pc); end
    tick();
    n_checks++; if (flush !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL jbf_end got flush=%b fv=%b want 0/1", flush, fetch_valid); end
    n_checks++; if (pc !== 32'h20 || redirect_cnt !== 32'd1) begin n_fail++; $display("FAIL jbf_state got pc=%h cnt=%0d want 20/1", pc, redirect_cnt); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) tick();
    n_checks++; if (pc !== 32'd8) begin n_fail++; $display("FAIL stall_start got %h want 8", pc); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (pc !== 32'd8 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold[%0d] got pc=%h fv=%b want 8/0", i, pc, fetch_valid); end
      tick();
    end
    stall = 1'b0;
    #1;
    n_checks++; if (pc !== 32'd8 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got pc=%h fv=%b want 8/1", pc, fetch_valid); end
    tick();
    n_checks++; if (pc !== 32'd9) begin n_fail++; $display("FAIL stall_advance got %h want 9", pc); end
  endtask

  task automatic test_halt_flush_reset();
    do_reset();
    jb_enable = 1'b1; jb_target_pc = 32'h30;
    tick();
    jb_enable = 1'b0; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (halted !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL hf_flush[%0d] got halted=%b flush=%b want 0/1", i, halted, flush); end
      tick();
    end
    n_checks++; if (halted !== 1'b0 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL hf_run got halted=%b fv=%b want 0/1", halted, fetch_valid); end
    tick();
    n_checks++; if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h30) begin n_fail++; $display("FAIL hf_halt got halted=%b fv=%b pc=%h want 1/0/30", halted, fetch_valid, pc); end
    trap_req = 1'b1; trap_vector = 32'h200; jb_enable = 1'b1; jb_target_pc = 32'h77;
    tick();
    tick();
    n_checks++; if (halted !== 1'b1 || trap_ack !== 1'b0 || pc !== 32'h30) begin n_fail++; $display("FAIL hf_ignore got halted=%b ack=%b pc=%h want 1/0/30", halted, trap_ack, pc); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (pc !== RST_PC || halted !== 1'b0 || trap_ack !== 1'b0) begin n_fail++; $display("FAIL hf_reset got pc=%h halted=%b ack=%b want %h/0/0", pc, halted, trap_ack, RST_PC); end
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;
    model_reset();
    #1;
    n_checks++; if (pc !== RST_PC || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL hf_restart got pc=%h fv=%b want %h/1", pc, fetch_valid, RST_PC); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    jb_enable = 1'b1; jb_target_pc = 32'hFFFF_FFFF;
    tick();
    jb_enable = 1'b0;
    repeat (3) tick();
    n_checks++; if (pc !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_top got %h want ffffffff", pc); end
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", pc); end
  endtask

  task automatic test_random();
    logic acked;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      jb_enable    = ($urandom_range(0, 99) < 15);
      jb_target_pc = $urandom;
      stall        = ($urandom_range(0, 99) < 20);
      imem_ready   = ($urandom_range(0, 99) < 80);
      if (!trap_req && $urandom_range(0, 99) < 6) begin
        trap_req = 1'b1; trap_vector = $urandom;
      end
      if ($urandom_range(0, 99) < 8) halt_req = ~halt_req;
      #2;
      n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d] got %h want %h", i, pc, m_pc); end
      n_checks++; if (fetch_valid !== exp_fv()) begin n_fail++; $display("FAIL rnd_fv[%0d] got %b want %b", i, fetch_valid, exp_fv()); end
      n_checks++; if (flush !== (m_flush_left > 0)) begin n_fail++; $display("FAIL rnd_flush[%0d] got %b want %b", i, flush, m_flush_left > 0); end
      n_checks++; if (trap_ack !== exp_ack()) begin n_fail++; $display("FAIL rnd_ack[%0d] got %b want %b", i, trap_ack, exp_ack()); end
      n_checks++; if (epc !== m_epc) begin n_fail++; $display("FAIL rnd_epc[%0d] got %h want %h", i, epc, m_epc); end
      n_checks++; if (halted !== m_halt) begin n_fail++; $display("FAIL rnd_halted[%0d] got %b want %b", i, halted, m_halt); end
      n_checks++; if (redirect_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", i, redirect_cnt, m_cnt); end
      acked = exp_ack();
      tick();
      if (acked) trap_req = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_jb_redirect();
    test_trap_jb();
    test_jb_in_flush();
    test_stall();
    test_halt_flush_reset();
    test_pc_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
